// File: rtl/ambiente_robo.sv
// Grid-world environment for the wall-following robot: turns avancar/girar/remover into pose,
// barrier-map updates and head/left/under/barrier sensors. Define AMBIENTE_TRACE_EN for an event trace.
module ambiente_robo #(
   parameter int                     MAP_W         = 8,
   parameter int                     MAP_H         = 8,
   parameter logic [MAP_W*MAP_H-1:0] WALL_MAP      = '0,
   parameter logic [MAP_W*MAP_H-1:0] BARRIER_MAP   = '0,
   parameter logic [MAP_W*MAP_H-1:0] HOLE_MAP      = '0,
   parameter int                     START_X       = 0,
   parameter int                     START_Y       = 0,
   parameter int                     START_DIR     = 0,
   parameter int                     REMOVE_CYCLES = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       avancar,
   input  logic                       girar,
   input  logic                       remover,
   output logic                       head,
   output logic                       left,
   output logic                       under,
   output logic                       barrier,
   output logic [$clog2(MAP_W)-1:0]   pos_x,
   output logic [$clog2(MAP_H)-1:0]   pos_y,
   output logic [1:0]                 dir,
   output logic [7:0]                 removed_count,
   output logic                       collision,
   output logic                       cmd_error
);

   localparam int          XW      = $clog2(MAP_W);
   localparam int          YW      = $clog2(MAP_H);
   localparam int          N       = MAP_W * MAP_H;
   localparam int          IW      = $clog2(N);
   localparam logic [3:0]  RC_LAST = 4'(REMOVE_CYCLES - 1);

   logic [N-1:0]  bar_map;
   logic [3:0]    rm_cnt;
   int            cx, cy, ax, ay, lx, ly;
   logic [IW-1:0] ahead_idx;
   logic          multi;

   // Out-of-bounds cells return oob, which is how the grid edge reads as wall.
   function automatic logic cell_bit(input logic [N-1:0] m, input int x, input int y,
                                     input logic oob);
      logic r;
      if (x < 0 || x >= MAP_W || y < 0 || y >= MAP_H) r = oob;
      else                                              r = m[IW'(y * MAP_W + x)];
      return r;
   endfunction

   function automatic int step_x(input logic [1:0] d);
      int r;
      case (d)
         2'd1:    r = 1;
         2'd3:    r = -1;
         default: r = 0;
      endcase
      return r;
   endfunction

   function automatic int step_y(input logic [1:0] d);
      int r;
      case (d)
         2'd0:    r = -1;
         2'd2:    r = 1;
         default: r = 0;
      endcase
      return r;
   endfunction

   always_comb begin
      cx        = int'(pos_x);
      cy        = int'(pos_y);
      ax        = cx + step_x(dir);
      ay        = cy + step_y(dir);
      lx        = cx + step_x(dir - 2'd1);
      ly        = cy + step_y(dir - 2'd1);
      head      = cell_bit(WALL_MAP, ax, ay, 1'b1);
      left      = cell_bit(WALL_MAP, lx, ly, 1'b1);
      barrier   = cell_bit(bar_map, ax, ay, 1'b0);
      under     = cell_bit(HOLE_MAP, cx, cy, 1'b0);
      // Only consumed when barrier=1 or head=0, both of which imply the ahead cell is on-grid.
      ahead_idx = IW'(ay * MAP_W + ax);
      multi     = (avancar & girar) | (avancar & remover) | (girar & remover);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pos_x         <= XW'(START_X);
         pos_y         <= YW'(START_Y);
         dir           <= 2'(START_DIR);
         bar_map       <= BARRIER_MAP;
         rm_cnt        <= '0;
         removed_count <= '0;
         collision     <= 1'b0;
         cmd_error     <= 1'b0;
      end else if (under) begin
         rm_cnt <= '0;
      end else begin
         rm_cnt <= '0;
         if (multi) begin
            cmd_error <= 1'b1;
         end else if (girar) begin
            dir <= dir + 2'd1;
         end else if (avancar) begin
            if (head | barrier) collision <= 1'b1;
            else begin
               pos_x <= XW'(ax);
               pos_y <= YW'(ay);
            end
         end else if (remover && barrier) begin
            if (rm_cnt == RC_LAST) begin
               bar_map[ahead_idx] <= 1'b0;
               if (removed_count != 8'hFF) removed_count <= removed_count + 8'd1;
            end else begin
               rm_cnt <= rm_cnt + 4'd1;
            end
         end
      end
   end

`ifdef AMBIENTE_TRACE_EN
   always @(posedge clock) begin
      if (!reset && !under) begin
         if (multi)
            $display("%0t amb (%0d,%0d) d%0d cmd_error", $time, pos_x, pos_y, dir);
         else if (girar)
            $display("%0t amb (%0d,%0d) d%0d turn", $time, pos_x, pos_y, dir);
         else if (avancar && (head | barrier))
            $display("%0t amb (%0d,%0d) d%0d move refused", $time, pos_x, pos_y, dir);
         else if (avancar)
            $display("%0t amb (%0d,%0d) d%0d move", $time, pos_x, pos_y, dir);
         else if (remover && barrier && rm_cnt == RC_LAST)
            $display("%0t amb (%0d,%0d) d%0d barrier cleared", $time, pos_x, pos_y, dir);
         else if (remover && barrier)
            $display("%0t amb (%0d,%0d) d%0d remove step %0d", $time, pos_x, pos_y, dir, rm_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_ambiente_robo.sv
// Scoreboard bench for ambiente_robo on an 8x8 map with two walls, one barrier and one hole;
// stimulus pushes hand-computed post-edge expectations, a monitor pops and compares each cycle.
module tb_ambiente_robo;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       avancar = 1'b0, girar = 1'b0, remover = 1'b0;
   logic       head, left, under, barrier, collision, cmd_error;
   logic [2:0] pos_x, pos_y;
   logic [1:0] dir;
   logic [7:0] removed_count;

   typedef struct {
      string      nm;
      logic [2:0] x, y;
      logic [1:0] d;
      logic       h, l, u, b;
      logic [7:0] rc;
      logic       c, e;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   bit   done  = 0;

   // Walls (5,1),(0,1); barrier (1,2); hole (1,0); start (1,1) facing E.
   ambiente_robo #(
      .MAP_W(8), .MAP_H(8),
      .WALL_MAP(64'h2100), .BARRIER_MAP(64'h20000), .HOLE_MAP(64'h2),
      .START_X(1), .START_Y(1), .START_DIR(1), .REMOVE_CYCLES(4)
   ) dut (
      .clock(clock), .reset(reset), .avancar(avancar), .girar(girar), .remover(remover),
      .head(head), .left(left), .under(under), .barrier(barrier),
      .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .removed_count(removed_count),
      .collision(collision), .cmd_error(cmd_error)
   );

   always #5 clock = ~clock;

   function automatic exp_t mk(input int x, input int y, input int d, input bit h, input bit l,
                               input bit u, input bit b, input int rc, input bit c, input bit e);
      exp_t r;
      r.nm = ""; r.x = 3'(x); r.y = 3'(y); r.d = 2'(d);
      r.h = h; r.l = l; r.u = u; r.b = b; r.rc = 8'(rc); r.c = c; r.e = e;
      return r;
   endfunction

   task automatic step(input string nm, input bit r, input bit a, input bit g, input bit m,
                       input exp_t e);
      @(negedge clock);
      reset = r; avancar = a; girar = g; remover = m;
      e.nm = nm;
      exp_q.push_back(e);
      @(posedge clock);
   endtask

   // Monitor: every cycle with a pending expectation, compare the post-edge state.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if ({pos_x, pos_y, dir, head, left, under, barrier, removed_count, collision, cmd_error} !==
                {e.x, e.y, e.d, e.h, e.l, e.u, e.b, e.rc, e.c, e.e}) begin
               fails++;
               $display("FAIL %s: got pos=(%0d,%0d) dir=%0d h%0b l%0b u%0b b%0b rc=%0d col%0b err%0b, want pos=(%0d,%0d) dir=%0d h%0b l%0b u%0b b%0b rc=%0d col%0b err%0b",
                        e.nm, pos_x, pos_y, dir, head, left, under, barrier, removed_count,
                        collision, cmd_error, e.x, e.y, e.d, e.h, e.l, e.u, e.b, e.rc, e.c, e.e);
            end
         end
      end
   end

   initial begin
      #200000;
      if (!done) begin
         $display("FAIL watchdog: bench did not finish in time");
         $fatal(1);
      end
   end

   initial begin
      // Free moves, wall refusal, full rotation, command conflict.
      step("rst_a",     1, 0, 0, 0, mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      step("rm_nobar",  0, 0, 0, 1, mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      step("mv1",       0, 1, 0, 0, mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      step("mv2",       0, 1, 0, 0, mk(3, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      step("mv3",       0, 1, 0, 0, mk(4, 1, 1, 1, 0, 0, 0, 0, 0, 0));
      step("wall_hit",  0, 1, 0, 0, mk(4, 1, 1, 1, 0, 0, 0, 0, 1, 0));
      step("turn_s",    0, 0, 1, 0, mk(4, 1, 2, 0, 1, 0, 0, 0, 1, 0));
      step("turn_w",    0, 0, 1, 0, mk(4, 1, 3, 0, 0, 0, 0, 0, 1, 0));
      step("turn_n",    0, 0, 1, 0, mk(4, 1, 0, 0, 0, 0, 0, 0, 1, 0));
      step("turn_e",    0, 0, 1, 0, mk(4, 1, 1, 1, 0, 0, 0, 0, 1, 0));
      step("multi",     0, 1, 1, 0, mk(4, 1, 1, 1, 0, 0, 0, 0, 1, 1));
      // Barrier: refusal, reset mid-removal, clean 4-cycle clear, move into cleared cell.
      step("rst_b",     1, 0, 0, 0, mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      step("face_bar",  0, 0, 1, 0, mk(1, 1, 2, 0, 0, 0, 1, 0, 0, 0));
      step("bar_hit",   0, 1, 0, 0, mk(1, 1, 2, 0, 0, 0, 1, 0, 1, 0));
      step("rm1",       0, 0, 0, 1, mk(1, 1, 2, 0, 0, 0, 1, 0, 1, 0));
      step("rm2",       0, 0, 0, 1, mk(1, 1, 2, 0, 0, 0, 1, 0, 1, 0));
      step("rst_mid",   1, 0, 0, 1, mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      step("face_bar2", 0, 0, 1, 0, mk(1, 1, 2, 0, 0, 0, 1, 0, 0, 0));
      step("rc1",       0, 0, 0, 1, mk(1, 1, 2, 0, 0, 0, 1, 0, 0, 0));
      step("rc2",       0, 0, 0, 1, mk(1, 1, 2, 0, 0, 0, 1, 0, 0, 0));
      step("rc3",       0, 0, 0, 1, mk(1, 1, 2, 0, 0, 0, 1, 0, 0, 0));
      step("rc4_clear", 0, 0, 0, 1, mk(1, 1, 2, 0, 0, 0, 0, 1, 0, 0));
      step("enter",     0, 1, 0, 0, mk(1, 2, 2, 0, 0, 0, 0, 1, 0, 0));
      // Gap after two cycles restarts the count.
      step("rst_c",     1, 0, 0, 0, mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      step("face_bar3", 0, 0, 1, 0, mk(1, 1, 2, 0, 0, 0, 1, 0, 0, 0));
      step("g_rm1",     0, 0, 0, 1, mk(1, 1, 2, 0, 0, 0, 1, 0, 0, 0));
      step("g_rm2",     0, 0, 0, 1, mk(1, 1, 2, 0, 0, 0, 1, 0, 0, 0));
      step("g_gap",     0, 0, 0, 0, mk(1, 1, 2, 0, 0, 0, 1, 0, 0, 0));
      step("g_rm3",     0, 0, 0, 1, mk(1, 1, 2, 0, 0, 0, 1, 0, 0, 0));
      step("g_rm4",     0, 0, 0, 1, mk(1, 1, 2, 0, 0, 0, 1, 0, 0, 0));
      step("g_rm5",     0, 0, 0, 1, mk(1, 1, 2, 0, 0, 0, 1, 0, 0, 0));
      step("g_rm6",     0, 0, 0, 1, mk(1, 1, 2, 0, 0, 0, 0, 1, 0, 0));
      step("rm_after",  0, 0, 0, 1, mk(1, 1, 2, 0, 0, 0, 0, 1, 0, 0));
      // Hole: enter, then every command is ignored; off-grid ahead reads as wall.
      step("rst_d",     1, 0, 0, 0, mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      step("h_turn_s",  0, 0, 1, 0, mk(1, 1, 2, 0, 0, 0, 1, 0, 0, 0));
      step("h_turn_w",  0, 0, 1, 0, mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
      step("h_turn_n",  0, 0, 1, 0, mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      step("h_enter",   0, 1, 0, 0, mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      step("h_frz_mv",  0, 1, 0, 0, mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      step("h_frz_g",   0, 0, 1, 0, mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      step("h_frz_mul", 0, 1, 1, 0, mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      step("h_frz_rm",  0, 0, 0, 1, mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      step("rst_e",     1, 0, 0, 0, mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clock);
      reset = 0; avancar = 0; girar = 0; remover = 0;
      repeat (3) @(posedge clock);
      #2;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      done = 1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
